// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: assembles two BCD operands from key strobes, runs the ALU, shows result.
// Optional CALC_CHAIN_EN: an operator key in SHOW chains the displayed result into a new operation.
module calc_seq_ctrl #(
  parameter int unsigned ALU_LAT = 2,
  parameter int unsigned NDIG    = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              key_vld,
  input  logic [3:0]        key_code,
  input  logic [4*NDIG-1:0] alu_res,
  output logic [4*NDIG-1:0] alu_num1,
  output logic [4*NDIG-1:0] alu_num2,
  output logic [3:0]        alu_op,
  output logic              alu_start,
  output logic [4*NDIG-1:0] disp,
  output logic              busy,
  output logic              res_vld
);

  localparam int unsigned W    = 4 * NDIG;
  localparam int unsigned CntW = $clog2(NDIG + 1);
  localparam logic [3:0]  LatLoad = 4'(ALU_LAT - 1);

  typedef enum logic [2:0] {StEntA, StOpSel, StEntB, StExec, StShow} state_t;

  state_t          state;
  logic [CntW-1:0] cnt;
  logic [3:0]      lat_cnt;

  logic            key_digit, key_op, key_eq, key_clr, cnt_room;
  logic [W-1:0]    digit_val, num1_shift, num2_shift;

  always_comb begin
    key_digit  = key_vld && (key_code <= 4'h9);
    key_op     = key_vld && (key_code >= 4'hA) && (key_code <= 4'hD);
    key_eq     = key_vld && (key_code == 4'hE);
    key_clr    = key_vld && (key_code == 4'hF);
    cnt_room   = cnt < CntW'(NDIG);
    digit_val  = {{(W-4){1'b0}}, key_code};
    num1_shift = {alu_num1[W-5:0], key_code};
    num2_shift = {alu_num2[W-5:0], key_code};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= StEntA;
      cnt       <= '0;
      lat_cnt   <= '0;
      alu_num1  <= '0;
      alu_num2  <= '0;
      alu_op    <= '0;
      alu_start <= 1'b0;
      disp      <= '0;
      busy      <= 1'b0;
      res_vld   <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      res_vld   <= 1'b0;
      if (key_clr) begin
        // Clear wins over everything, including a result about to be captured.
        state    <= StEntA;
        cnt      <= '0;
        lat_cnt  <= '0;
        alu_num1 <= '0;
        alu_num2 <= '0;
        alu_op   <= '0;
        disp     <= '0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          StEntA: begin
            if (key_digit) begin
              if (cnt_room) begin
                alu_num1 <= num1_shift;
                disp     <= num1_shift;
                cnt      <= cnt + CntW'(1);
              end
            end else if (key_op) begin
              alu_op <= key_code;
              cnt    <= '0;
              state  <= StOpSel;
            end
          end
          StOpSel: begin
            if (key_op) begin
              alu_op <= key_code;
            end else if (key_digit) begin
              alu_num2 <= digit_val;
              disp     <= digit_val;
              cnt      <= CntW'(1);
              state    <= StEntB;
            end else if (key_eq) begin
              alu_num2  <= '0;
              state     <= StExec;
              alu_start <= 1'b1;
              busy      <= 1'b1;
              lat_cnt   <= LatLoad;
            end
          end
          StEntB: begin
            if (key_digit) begin
              if (cnt_room) begin
                alu_num2 <= num2_shift;
                disp     <= num2_shift;
                cnt      <= cnt + CntW'(1);
              end
            end else if (key_eq) begin
              state     <= StExec;
              alu_start <= 1'b1;
              busy      <= 1'b1;
              lat_cnt   <= LatLoad;
            end
          end
          StExec: begin
            if (lat_cnt == 4'd0) begin
              disp    <= alu_res;
              res_vld <= 1'b1;
              busy    <= 1'b0;
              state   <= StShow;
            end else begin
              lat_cnt <= lat_cnt - 4'd1;
            end
          end
          StShow: begin
            if (key_digit) begin
              alu_num1 <= digit_val;
              alu_num2 <= '0;
              disp     <= digit_val;
              cnt      <= CntW'(1);
              state    <= StEntA;
            end
`ifdef CALC_CHAIN_EN
            else if (key_op) begin
              alu_num1 <= disp;
              alu_num2 <= '0;
              alu_op   <= key_code;
              cnt      <= '0;
              state    <= StOpSel;
            end
`endif
          end
          default: state <= StEntA;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: directed scenarios then random keys vs. a timestamp model.
// A second instance with ALU latency 4 exercises clear during a long execution.
module tb_calc_seq_ctrl;
  localparam int unsigned LAT  = 2;
  localparam int unsigned NDIG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, key_vld, key_vld4;
  logic [3:0]  key_code, key_code4;
  logic [15:0] alu_res;
  logic [15:0] alu_num1, alu_num2, disp;
  logic [3:0]  alu_op;
  logic        alu_start, busy, res_vld;
  logic [15:0] alu_num1_4, alu_num2_4, disp4;
  logic [3:0]  alu_op4;
  logic        alu_start4, busy4, res_vld4;

  calc_seq_ctrl #(.ALU_LAT(LAT), .NDIG(NDIG)) u_dut (
    .clk(clk), .resetn(resetn), .key_vld(key_vld), .key_code(key_code), .alu_res(alu_res),
    .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op(alu_op), .alu_start(alu_start),
    .disp(disp), .busy(busy), .res_vld(res_vld)
  );

  calc_seq_ctrl #(.ALU_LAT(4), .NDIG(NDIG)) u_dut4 (
    .clk(clk), .resetn(resetn), .key_vld(key_vld4), .key_code(key_code4), .alu_res(16'h9999),
    .alu_num1(alu_num1_4), .alu_num2(alu_num2_4), .alu_op(alu_op4), .alu_start(alu_start4),
    .disp(disp4), .busy(busy4), .res_vld(res_vld4)
  );

  int n_chk = 0;
  int n_err = 0;
  int rv_seen = 0;
  int rv4_seen = 0;

  // Reference model: phase plus absolute cycle at which the running calculation completes.
  typedef enum {PhA, PhOp, PhB, PhExec, PhShow} ph_t;
  ph_t         m_ph;
  logic [15:0] m_n1, m_n2, m_disp;
  logic [3:0]  m_op;
  logic        m_start, m_busy, m_rv;
  int          m_cnt, cyc, m_done_at;

  function automatic logic [15:0] push_digit(input logic [15:0] v, input logic [3:0] d);
    return 16'((32'(v) * 32'd16 + 32'(d)) % 32'h10000);
  endfunction

  task automatic m_reset();
    m_ph = PhA; m_n1 = '0; m_n2 = '0; m_disp = '0; m_op = '0;
    m_start = 1'b0; m_busy = 1'b0; m_rv = 1'b0; m_cnt = 0; m_done_at = 0;
  endtask

  task automatic m_go_exec();
    m_ph = PhExec; m_start = 1'b1; m_busy = 1'b1; m_done_at = cyc + LAT;
  endtask

  task automatic m_edge(input logic v, input logic [3:0] k);
    logic is_d, is_op, is_eq;
    cyc++;
    m_start = 1'b0;
    m_rv    = 1'b0;
    is_d  = v && (k <= 4'h9);
    is_op = v && (k >= 4'hA) && (k <= 4'hD);
    is_eq = v && (k == 4'hE);
    if (v && k == 4'hF) begin
      m_reset();
    end else if (m_ph == PhExec) begin
      if (cyc == m_done_at) begin
        m_disp = alu_res; m_rv = 1'b1; m_busy = 1'b0; m_ph = PhShow;
      end
    end else begin
      case (m_ph)
        PhA: begin
          if (is_d) begin
            if (m_cnt < NDIG) begin m_n1 = push_digit(m_n1, k); m_cnt++; m_disp = m_n1; end
          end else if (is_op) begin
            m_op = k; m_cnt = 0; m_ph = PhOp;
          end
        end
        PhOp: begin
          if (is_op) m_op = k;
          else if (is_d) begin m_n2 = 16'(k); m_disp = m_n2; m_cnt = 1; m_ph = PhB; end
          else if (is_eq) begin m_n2 = '0; m_go_exec(); end
        end
        PhB: begin
          if (is_d) begin
            if (m_cnt < NDIG) begin m_n2 = push_digit(m_n2, k); m_cnt++; m_disp = m_n2; end
          end else if (is_eq) m_go_exec();
        end
        PhShow: begin
          if (is_d) begin
            m_n1 = 16'(k); m_n2 = '0; m_disp = m_n1; m_cnt = 1; m_ph = PhA;
          end
`ifdef CALC_CHAIN_EN
          else if (is_op) begin
            m_n1 = m_disp; m_op = k; m_n2 = '0; m_cnt = 0; m_ph = PhOp;
          end
`endif
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("num1", alu_num1, m_n1);
    chk("num2", alu_num2, m_n2);
    chk("op", 16'(alu_op), 16'(m_op));
    chk("start", 16'(alu_start), 16'(m_start));
    chk("disp", disp, m_disp);
    chk("busy", 16'(busy), 16'(m_busy));
    chk("res_vld", 16'(res_vld), 16'(m_rv));
  endtask

  task automatic step(input logic v, input logic [3:0] k);
    @(negedge clk);
    key_vld = v; key_code = k;
    @(posedge clk);
    m_edge(v, k);
    #1;
    check_all();
    if (res_vld) rv_seen++;
  endtask

  task automatic step4(input logic v, input logic [3:0] k);
    @(negedge clk);
    key_vld = 1'b0; key_vld4 = v; key_code4 = k;
    @(posedge clk);
    m_edge(1'b0, 4'h0);
    #1;
    check_all();
    if (res_vld4) rv4_seen++;
  endtask

  initial begin
    logic [3:0] k;
    int r;
    resetn = 1'b0; key_vld = 1'b0; key_code = '0; key_vld4 = 1'b0; key_code4 = '0;
    alu_res = '0; cyc = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst4_disp", disp4, 16'h0000);
    chk("rst4_busy", 16'(busy4), 16'h0000);
    @(negedge clk) resetn = 1'b1;

    step(1'b1, 4'h1); step(1'b1, 4'h2); step(1'b0, 4'h0);
    chk("disp_12", disp, 16'h0012);

    // Asynchronous reset in the middle of operand B entry.
    step(1'b1, 4'hA); step(1'b1, 4'h7);
    @(negedge clk);
    key_vld = 1'b0;
    #2 resetn = 1'b0;
    #1 m_reset();
    check_all();
    @(negedge clk) resetn = 1'b1;
    step(1'b1, 4'h1); step(1'b1, 4'h2);
    chk("post_rst_disp", disp, 16'h0012);

    // 12+34=
    step(1'b1, 4'hF);
    step(1'b1, 4'h1); step(1'b1, 4'h2); step(1'b1, 4'hA); step(1'b1, 4'h3); step(1'b1, 4'h4);
    alu_res = 16'h0046;
    step(1'b1, 4'hE);
    chk("add_num1", alu_num1, 16'h0012);
    chk("add_num2", alu_num2, 16'h0034);
    chk("add_op", 16'(alu_op), 16'h000A);
    chk("add_start_n1", 16'(alu_start), 16'h0001);
    step(1'b0, 4'h0);
    chk("add_rv_n2", 16'(res_vld), 16'h0000);
    step(1'b0, 4'h0);
    chk("add_rv_n3", 16'(res_vld), 16'h0001);
    chk("add_disp", disp, 16'h0046);

    // Fifth digit dropped, operator replaced in OP_SEL.
    step(1'b1, 4'hF);
    step(1'b1, 4'h1); step(1'b1, 4'h2); step(1'b1, 4'h3); step(1'b1, 4'h4); step(1'b1, 4'h5);
    chk("ovf_num1", alu_num1, 16'h1234);
    step(1'b1, 4'hA); step(1'b1, 4'hB);
    chk("op_replace", 16'(alu_op), 16'h000B);

    // Keys during EXEC are ignored; exactly one result pulse.
    step(1'b1, 4'h3);
    alu_res = 16'h1357;
    rv_seen = 0;
    step(1'b1, 4'hE); step(1'b1, 4'h9); step(1'b1, 4'hC); step(1'b1, 4'hE);
    step(1'b0, 4'h0); step(1'b0, 4'h0);
    chk("exec_keys_rv", 16'(rv_seen), 16'h0001);
    chk("exec_keys_num1", alu_num1, 16'h1234);
    chk("exec_keys_num2", alu_num2, 16'h0003);
    chk("exec_keys_op", 16'(alu_op), 16'h000B);
    chk("exec_keys_disp", disp, 16'h1357);

    // Chain: 2+3=+4=
    step(1'b1, 4'hF);
    step(1'b1, 4'h2); step(1'b1, 4'hA); step(1'b1, 4'h3);
    alu_res = 16'h0005;
    step(1'b1, 4'hE); step(1'b0, 4'h0); step(1'b0, 4'h0); step(1'b0, 4'h0);
    step(1'b1, 4'hA); step(1'b1, 4'h4); step(1'b1, 4'hE);
`ifdef CALC_CHAIN_EN
    chk("chain_num1", alu_num1, 16'h0005);
    chk("chain_num2", alu_num2, 16'h0004);
    chk("chain_start", 16'(alu_start), 16'h0001);
`else
    chk("nochain_num1", alu_num1, 16'h0004);
    chk("nochain_num2", alu_num2, 16'h0000);
    chk("nochain_busy", 16'(busy), 16'h0000);
`endif
    step(1'b0, 4'h0); step(1'b0, 4'h0); step(1'b0, 4'h0);

    // Clear two cycles after alu_start on the latency-4 instance.
    step4(1'b1, 4'h1); step4(1'b1, 4'hA); step4(1'b1, 4'h2); step4(1'b1, 4'hE);
    chk("clr4_start", 16'(alu_start4), 16'h0001);
    step4(1'b0, 4'h0); step4(1'b0, 4'h0);
    chk("clr4_busy_before", 16'(busy4), 16'h0001);
    rv4_seen = 0;
    step4(1'b1, 4'hF);
    for (int i = 0; i < 6; i++) step4(1'b0, 4'h0);
    chk("clr4_no_rv", 16'(rv4_seen), 16'h0000);
    chk("clr4_disp", disp4, 16'h0000);
    chk("clr4_busy", 16'(busy4), 16'h0000);
    chk("clr4_num1", alu_num1_4, 16'h0000);
    chk("clr4_op", 16'(alu_op4), 16'h0000);

    // Random key traffic with a changing ALU result.
    for (int i = 0; i < 800; i++) begin
      alu_res = 16'($urandom);
      r = int'($urandom_range(0, 19));
      if (r == 0) k = 4'hF;
      else if (r < 12) k = 4'($urandom_range(0, 9));
      else if (r < 16) k = 4'($urandom_range(10, 13));
      else k = 4'hE;
      step(($urandom_range(0, 2) != 0), k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
